// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time_keeper clock:
//   state_t     : mode FSM encoding (RUN, SET_HOUR, SET_MIN, SET_SEC)
//   HOUR_MAX_T  : highest hour tens digit (2)
//   HOUR_MAX_U  : hour units digit at which the hour wraps (3, i.e. 23)
//   MIN_MAX_T   : highest minute/second tens digit (5)
//   DIGIT_MAX   : highest decimal digit (9)
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } state_t;

  localparam int HOUR_MAX_T = 2;
  localparam int HOUR_MAX_U = 3;
  localparam int MIN_MAX_T  = 5;
  localparam int DIGIT_MAX  = 9;

endpackage

// File: rtl/bcd_pair_counter.sv
// -----------------------------------------------------------------------------
// bcd_pair_counter
// Two-digit BCD counter (tens:units) that wraps to 00 after MAX_TENS:MAX_UNITS.
// Digits are held directly in BCD; units 9->0 increments tens.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (digits -> 00)
//   inc    in   increment by one this cycle
//   tens   out  registered BCD tens digit
//   units  out  registered BCD units digit
//   carry  out  combinational: inc while at the maximum value (wrap this edge)
// -----------------------------------------------------------------------------
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MAX_TENS  = 5,
  parameter int MAX_UNITS = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_max;

  assign w_at_max = (r_tens == 4'(MAX_TENS)) && (r_units == 4'(MAX_UNITS));
  assign carry    = inc && w_at_max;
  assign tens     = r_tens;
  assign units    = r_units;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= '0;
      r_units <= '0;
    end else if (inc) begin
      if (w_at_max) begin
        r_tens  <= '0;
        r_units <= '0;
      end else if (r_units == 4'(DIGIT_MAX)) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= '0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// HH:MM:SS BCD time-of-day clock with two-button setting and blinking edit field.
// Optional macro: TIME_12H_EN -- hour outputs shown in 12-hour form plus pm port.
// Ports:
//   clk                    in   system clock, rising edge
//   rst_n                  in   asynchronous active-low reset
//   btn_mode               in   1-cycle pulse, RUN->SET_HOUR->SET_MIN->SET_SEC->RUN
//   btn_inc                in   1-cycle pulse, increments the edited field
//   hour_tens/hour_units   out  BCD hour digits (24h, or 12h with TIME_12H_EN)
//   min_tens/min_units     out  BCD minute digits
//   sec_tens/sec_units     out  BCD second digits
//   ena                    out  digit enables [5:4] h, [3:2] m, [1:0] s; 1 = lit
//   pm                     out  PM indicator (TIME_12H_EN builds only)
// -----------------------------------------------------------------------------
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [5:0] ena
`ifdef TIME_12H_EN
  ,
  output logic       pm
`endif
);

  // One width serves both counters; CLK_HZ >= 4 keeps it at least 2 bits.
  localparam int            PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] BLINK_TC = PW'(CLK_HZ / 4 - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] r_blink;
  logic [PW-1:0] w_blink_nxt;
  logic          r_phase;
  logic          w_phase_nxt;
  logic [5:0]    r_ena;
  logic [5:0]    w_ena_nxt;

  logic          w_run;
  logic          w_inc_ok;
  logic          w_tick;
  logic          w_sec_inc;
  logic          w_min_inc;
  logic          w_hour_inc;
  logic          w_sec_carry;
  logic          w_min_carry;
  logic [3:0]    w_hour_t;
  logic [3:0]    w_hour_u;

  // btn_mode has priority: it swallows a simultaneous inc or terminal tick.
  assign w_run    = (r_state == RUN);
  assign w_inc_ok = btn_inc && !btn_mode;
  assign w_tick   = w_run && (r_presc == PRESC_TC) && !btn_mode;

  // Carries only ripple while running; in set mode each field wraps alone.
  assign w_sec_inc  = w_tick || ((r_state == SET_SEC) && w_inc_ok);
  assign w_min_inc  = (w_run && w_sec_carry) || ((r_state == SET_MIN) && w_inc_ok);
  assign w_hour_inc = (w_run && w_min_carry) || ((r_state == SET_HOUR) && w_inc_ok);

  bcd_pair_counter #(.MAX_TENS(MIN_MAX_T), .MAX_UNITS(DIGIT_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_sec_inc),
    .tens  (sec_tens),
    .units (sec_units),
    .carry (w_sec_carry)
  );

  bcd_pair_counter #(.MAX_TENS(MIN_MAX_T), .MAX_UNITS(DIGIT_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_min_inc),
    .tens  (min_tens),
    .units (min_units),
    .carry (w_min_carry)
  );

  // Day rollover needs no further action, so the hour carry is left open.
  bcd_pair_counter #(.MAX_TENS(HOUR_MAX_T), .MAX_UNITS(HOUR_MAX_U)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hour_inc),
    .tens  (w_hour_t),
    .units (w_hour_u),
    .carry ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, blink phase and the enable mask that goes with them, so ena
  // changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    if (btn_mode) begin
      w_state_nxt = state_t'(r_state + 2'd1);
    end

    w_blink_nxt = r_blink + PW'(1);
    w_phase_nxt = r_phase;
    if (btn_mode || btn_inc) begin
      w_blink_nxt = '0;
      w_phase_nxt = 1'b1;
    end else if (r_blink == BLINK_TC) begin
      w_blink_nxt = '0;
      w_phase_nxt = ~r_phase;
    end

    w_ena_nxt = 6'b111111;
    case (w_state_nxt)
      SET_HOUR: w_ena_nxt[5:4] = {2{w_phase_nxt}};
      SET_MIN:  w_ena_nxt[3:2] = {2{w_phase_nxt}};
      SET_SEC:  w_ena_nxt[1:0] = {2{w_phase_nxt}};
      default:  w_ena_nxt      = 6'b111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_blink <= '0;
      r_phase <= 1'b1;
      r_ena   <= 6'b111111;
    end else begin
      // Leaving RUN (or staying in set mode) parks the prescaler at 0 so the
      // first second after returning to RUN is a full one.
      if (btn_mode || !w_run || (r_presc == PRESC_TC)) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_blink <= w_blink_nxt;
      r_phase <= w_phase_nxt;
      r_ena   <= w_ena_nxt;
    end
  end

  assign ena = r_ena;

`ifdef TIME_12H_EN
  // Pure decode of the registered 24-hour digits: returns {pm, tens, units}.
  function automatic logic [8:0] map_12h(input logic [3:0] t, input logic [3:0] u);
    logic [8:0] r;
    r = {1'b0, t, u};
    case (t)
      4'd0: begin
        if (u == 4'd0) r = {1'b0, 4'd1, 4'd2};
      end
      4'd1: begin
        if (u == 4'd2)      r = {1'b1, 4'd1, 4'd2};
        else if (u > 4'd2)  r = {1'b1, 4'd0, u - 4'd2};
      end
      default: begin
        if (u >= 4'd2) r = {1'b1, 4'd1, u - 4'd2};
        else           r = {1'b1, 4'd0, u + 4'd8};
      end
    endcase
    return r;
  endfunction

  logic [8:0] w_h12;
  assign w_h12      = map_12h(w_hour_t, w_hour_u);
  assign pm         = w_h12[8];
  assign hour_tens  = w_h12[7:4];
  assign hour_units = w_h12[3:0];
`else
  assign hour_tens  = w_hour_t;
  assign hour_units = w_hour_u;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
// Self-checking bench for time_keeper at CLK_HZ = 8. A reference model holds
// the time as seconds-of-day and the mode as an integer; every cycle its
// expected digits, enables (and pm in TIME_12H_EN builds) are compared with
// the DUT outputs.
// -----------------------------------------------------------------------------
module tb_time_keeper;

  localparam int CLK_HZ = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
  logic [5:0] ena;
`ifdef TIME_12H_EN
  logic       pm;
`endif

  time_keeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .hour_tens  (hour_tens),
    .hour_units (hour_units),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .ena        (ena)
`ifdef TIME_12H_EN
    ,
    .pm         (pm)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_tsec;   // seconds since midnight
  int m_mode;   // 0 run, 1 hour, 2 min, 3 sec
  int m_presc;
  int m_bcnt;
  bit m_phase;

  task automatic model_reset();
    m_tsec = 0; m_mode = 0; m_presc = 0; m_bcnt = 0; m_phase = 1'b1;
  endtask

  task automatic model_cycle(input bit m, input bit i);
    int h, mi, s;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    if (m) begin
      m_mode = (m_mode + 1) % 4;
      m_presc = 0; m_bcnt = 0; m_phase = 1'b1;
    end else begin
      if (m_mode == 0) begin
        if (m_presc == CLK_HZ - 1) begin
          m_presc = 0;
          m_tsec = (m_tsec + 1) % 86400;
        end else begin
          m_presc++;
        end
      end else begin
        m_presc = 0;
        if (i) begin
          if (m_mode == 1) h = (h + 1) % 24;
          if (m_mode == 2) mi = (mi + 1) % 60;
          if (m_mode == 3) s = (s + 1) % 60;
          m_tsec = h * 3600 + mi * 60 + s;
        end
      end
      if (i) begin
        m_bcnt = 0; m_phase = 1'b1;
      end else if (m_bcnt == CLK_HZ / 4 - 1) begin
        m_bcnt = 0; m_phase = !m_phase;
      end else begin
        m_bcnt++;
      end
    end
  endtask

  function automatic logic [23:0] exp_digits();
    int h, hd, mi, s;
    h  = m_tsec / 3600;
    mi = (m_tsec / 60) % 60;
    s  = m_tsec % 60;
    hd = h;
`ifdef TIME_12H_EN
    hd = (h % 12 == 0) ? 12 : h % 12;
`endif
    return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [5:0] exp_ena();
    logic [5:0] e;
    e = 6'b111111;
    if (m_mode == 1) e[5:4] = {2{m_phase}};
    if (m_mode == 2) e[3:2] = {2{m_phase}};
    if (m_mode == 3) e[1:0] = {2{m_phase}};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".digits"},
          {8'h0, hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units},
          {8'h0, exp_digits()});
    check({tag, ".ena"}, {26'h0, ena}, {26'h0, exp_ena()});
`ifdef TIME_12H_EN
    check({tag, ".pm"}, {31'h0, pm}, {31'h0, (m_tsec / 3600) >= 12});
`endif
  endtask

  // One clock cycle with the given button pulses, then check every output.
  task automatic step(input bit m, input bit i, input string tag);
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk);
    model_cycle(m, i);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check_all(tag);
  endtask

  task automatic incs(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
`ifdef TIME_12H_EN
    check("reset.h12", {24'h0, hour_tens, hour_units}, 32'h12);
`endif
    rst_n = 1'b1;

    // First second after reset lasts CLK_HZ cycles
    idle(CLK_HZ - 1, "run0");
    check("sec_not_yet", {28'h0, sec_units}, 32'd0);
    idle(1, "run1");
    check("first_second", {28'h0, sec_units}, 32'd1);

    // Preload 23:59:59 via set mode, return to RUN, full rollover
    step(1'b1, 1'b0, "to_set_hour");
    incs(22, "set_h");       // hours were 00 -> 22
    incs(1, "set_h23");
    step(1'b1, 1'b0, "to_set_min");
    incs(59, "set_m");
    step(1'b1, 1'b0, "to_set_sec");
    incs(58, "set_s");       // seconds were 01 -> 59
    step(1'b1, 1'b0, "to_run");
    check("preload", {8'h0, hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units},
          exp_digits() == 24'h235959 ? 32'h235959 : 32'h0 - 1);
    idle(CLK_HZ, "rollover");
    check("midnight", {8'h0, min_tens, min_units, sec_tens, sec_units, 8'h0}, 32'h0);

    // Hours walk 00 -> 23 -> 00 -> 01 in SET_HOUR, nothing else moves
    step(1'b1, 1'b0, "to_set_hour2");
    incs(25, "hour_walk");
    check("hour_walk_end", {8'h0, min_tens, min_units, sec_tens, sec_units, 8'h0}, 32'h0);

    // Blink in SET_MIN, then btn_inc forces the field back on
    step(1'b1, 1'b0, "to_set_min2");
    idle(8, "blink");
    idle(1, "blink_off");
    step(1'b0, 1'b1, "blink_inc");
    check("blink_forced_on", {30'h0, ena[3:2]}, 32'd3);

    // btn_mode beats btn_inc
    step(1'b1, 1'b0, "to_set_sec2");
    step(1'b1, 1'b0, "to_run2");
    step(1'b1, 1'b0, "to_set_hour3");
    step(1'b1, 1'b1, "mode_and_inc");
    // back to RUN, then btn_mode on the terminal-count cycle
    step(1'b1, 1'b0, "to_set_sec3");
    step(1'b1, 1'b0, "to_run3");
    idle(CLK_HZ - 1, "pre_tick");
    step(1'b1, 1'b0, "mode_on_tick");
    check("tick_dropped", {28'h0, sec_units}, 32'(exp_digits() & 24'hF));

    // Randomized traffic against the model
    while (m_mode != 0) step(1'b1, 1'b0, "to_run4");
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) == 0), "rand");
    end

    // Reset asserted mid-SET_SEC
    while (m_mode != 3) step(1'b1, 1'b0, "to_set_sec4");
    incs(3, "pre_reset");
    btn_inc = 1'b1;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    btn_inc = 1'b0;
    check_all("reset_held");
    rst_n = 1'b1;
    idle(CLK_HZ, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net: the run is a fixed number of cycles, this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
